write_back_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back select for the 5-stage MIPS core; sits directly downstream of the memory stage.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/write_back_stage_retire_counter.sv | 23 ++
 rtl/write_back_stage.sv | 85 ++++++++
 tb/tb_write_back_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the 5-stage MIPS core.
// Inter-stage bundles and per-stage state encodings.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        WB_RUN,
        WB_HOLD
    } wb_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     alu_result;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  regWrite;
        logic                  memToReg;
    } mem_wb_t;

endpackage

// File: rtl/write_back_stage_retire_counter.sv
// Retired-instruction counter for the write-back stage.
// Wraps at 2^CNT_W; a clear request beats a simultaneous retire.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register, write-back select and load-data hold.
// Drives the register-file write port and the WB forwarding value.
module write_back_stage #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_ex_mem,
    input  logic [DATA_W-1:0]     alu_result_ex_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_ex_mem,
    input  logic                  ctrl_regWrite_ex_mem,
    input  logic                  ctrl_memToReg_ex_mem,
    input  logic [DATA_W-1:0]     read_data_from_mem,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  cnt_clear,
    output logic [DATA_W-1:0]     write_back_data,
    output logic [REG_ADDR_W-1:0] write_reg_wb,
    output logic                  ctrl_regWrite_wb,
    output logic [CNT_W-1:0]      retired_count
);

    import mips_pkg::*;

    mem_wb_t           wb_q;
    wb_state_t         state_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] load_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q    <= '0;
            state_q <= WB_RUN;
            hold_q  <= '0;
        end else begin
            if (flush) begin
                wb_q.valid    <= 1'b0;
                wb_q.regWrite <= 1'b0;
            end else if (!stall) begin
                wb_q <= '{
                    valid:      valid_ex_mem,
                    alu_result: alu_result_ex_mem,
                    write_reg:  write_reg_ex_mem,
                    regWrite:   ctrl_regWrite_ex_mem,
                    memToReg:   ctrl_memToReg_ex_mem
                };
            end
            // Memory re-reads every edge, so capture the live word on stall entry.
            unique case (state_q)
                WB_RUN: begin
                    if (stall && !flush) begin
                        hold_q  <= read_data_from_mem;
                        state_q <= WB_HOLD;
                    end
                end
                WB_HOLD: begin
                    if (!stall || flush) begin
                        state_q <= WB_RUN;
                    end
                end
                default: state_q <= WB_RUN;
            endcase
        end
    end

    assign load_src = (state_q == WB_HOLD) ? hold_q : read_data_from_mem;

    assign write_back_data  = wb_q.memToReg ? load_src : wb_q.alu_result;
    assign write_reg_wb     = wb_q.write_reg;
    assign ctrl_regWrite_wb = wb_q.valid & wb_q.regWrite
                            & (wb_q.write_reg != '0);

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (wb_q.valid & ~stall),
        .count  (retired_count)
    );

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: directed cases plus random
// traffic against a behavioural model of the WB outputs.
module tb_write_back_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex_mem;
    logic [31:0] alu_result_ex_mem;
    logic [4:0]  write_reg_ex_mem;
    logic        ctrl_regWrite_ex_mem;
    logic        ctrl_memToReg_ex_mem;
    logic [31:0] read_data_from_mem;
    logic        stall;
    logic        flush;
    logic        cnt_clear;
    logic [31:0] write_back_data;
    logic [4:0]  write_reg_wb;
    logic        ctrl_regWrite_wb;
    logic [CNT_W-1:0] retired_count;

    write_back_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .valid_ex_mem         (valid_ex_mem),
        .alu_result_ex_mem    (alu_result_ex_mem),
        .write_reg_ex_mem     (write_reg_ex_mem),
        .ctrl_regWrite_ex_mem (ctrl_regWrite_ex_mem),
        .ctrl_memToReg_ex_mem (ctrl_memToReg_ex_mem),
        .read_data_from_mem   (read_data_from_mem),
        .stall                (stall),
        .flush                (flush),
        .cnt_clear            (cnt_clear),
        .write_back_data      (write_back_data),
        .write_reg_wb         (write_reg_wb),
        .ctrl_regWrite_wb     (ctrl_regWrite_wb),
        .retired_count        (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          vld;
        logic [31:0] data;
        logic [4:0]  rg;
        logic        we;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: the instruction currently sitting in WB, plus a frozen output.
    bit          m_valid;
    logic [31:0] m_alu;
    logic [4:0]  m_reg;
    bit          m_rw;
    bit          m_m2r;
    bit          m_frozen;
    logic [31:0] m_frozen_data;
    logic [31:0] m_prev_data;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("we", {31'd0, ctrl_regWrite_wb}, {31'd0, e.we});
            check("count", {28'd0, retired_count}, {28'd0, e.cnt});
            if (e.vld) begin
                check("data", write_back_data, e.data);
                check("reg", {27'd0, write_reg_wb}, {27'd0, e.rg});
            end
        end
    end

    function automatic void model_clear();
        m_valid       = 0;
        m_alu         = '0;
        m_reg         = '0;
        m_rw          = 0;
        m_m2r         = 0;
        m_frozen      = 0;
        m_frozen_data = '0;
        m_prev_data   = '0;
        m_cnt         = 0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.data = m_frozen ? m_frozen_data
                          : (m_m2r ? read_data_from_mem : m_alu);
        m_prev_data = e.data;
        e.vld = m_valid;
        e.rg  = m_reg;
        e.we  = m_valid && m_rw && (m_reg != 0);
        e.cnt = 4'(m_cnt);
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit v, input logic [31:0] alu,
                        input logic [4:0] rg, input bit rw, input bit m2r,
                        input bit st, input bit fl, input bit clr,
                        input logic [31:0] rd);
        valid_ex_mem         = v;
        alu_result_ex_mem    = alu;
        write_reg_ex_mem     = rg;
        ctrl_regWrite_ex_mem = rw;
        ctrl_memToReg_ex_mem = m2r;
        stall                = st;
        flush                = fl;
        cnt_clear            = clr;
        @(posedge clk);
        #1;
        read_data_from_mem = rd;
        if (clr)
            m_cnt = 0;
        else if (m_valid && !st)
            m_cnt = (m_cnt + 1) % 16;
        if (fl) begin
            m_valid  = 0;
            m_rw     = 0;
            m_frozen = 0;
        end else if (st) begin
            if (!m_frozen) begin
                m_frozen      = 1;
                m_frozen_data = m_prev_data;
            end
        end else begin
            m_valid  = v;
            m_alu    = alu;
            m_reg    = rg;
            m_rw     = rw;
            m_m2r    = m2r;
            m_frozen = 0;
        end
        push_exp();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_data", write_back_data, 32'd0);
        check("rst_we", {31'd0, ctrl_regWrite_wb}, 32'd0);
        check("rst_cnt", {28'd0, retired_count}, 32'd0);
        model_clear();
        valid_ex_mem = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        cnt_clear    = 1'b0;
        push_exp();
        repeat (2) begin
            @(posedge clk);
            #1;
            push_exp();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset                = 1'b1;
        valid_ex_mem         = 1'b0;
        alu_result_ex_mem    = '0;
        write_reg_ex_mem     = '0;
        ctrl_regWrite_ex_mem = 1'b0;
        ctrl_memToReg_ex_mem = 1'b0;
        read_data_from_mem   = '0;
        stall                = 1'b0;
        flush                = 1'b0;
        cnt_clear            = 1'b0;
        model_clear();
        do_reset();

        // ALU write-back, then a load held across a 3-cycle stall
        step(1, 32'h0000_1234, 5'd8, 1, 0, 0, 0, 0, 32'h5555_0000);
        step(1, 32'h0000_0040, 5'd9, 1, 1, 0, 0, 0, 32'hDEAD_BEEF);
        repeat (3)
            step(1, 32'h7, 5'd3, 1, 0, 1, 0, 0, 32'h1111_1111);
        step(1, 32'h7, 5'd3, 1, 0, 0, 0, 0, 32'h2222_2222);

        // $0 destination, then flush and stall on the same edge
        step(1, 32'h5, 5'd0, 1, 0, 0, 0, 0, 32'h0);
        step(1, 32'h6, 5'd4, 1, 0, 1, 1, 0, 32'h0);
        step(0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0);

        // Counter wrap from a clean clear, then clear beating a retire
        step(0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 17; i++)
            step(1, 32'(i), 5'(i + 1), 1, 0, 0, 0, 0, 32'h0);
        step(1, 32'h9, 5'd2, 1, 0, 0, 0, 1, 32'h0);
        step(0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0);

        // Reset in the middle of a load stall
        step(1, 32'h1, 5'd6, 1, 1, 0, 0, 0, 32'hCAFE_0001);
        step(1, 32'h2, 5'd7, 1, 0, 1, 0, 0, 32'hCAFE_0002);
        do_reset();
        step(0, 32'h3, 5'd7, 1, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0),
                 $urandom(),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 4) != 0),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0),
                 $urandom());
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
